// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS datapath.
// Produces the EX operand forward selects and detects load-use hazards.
// It also stalls the front end while the multi-cycle mult/div unit is busy,
// and flushes IF/ID and ID/EX when a branch or jump in EX is taken.
// Optional build macro HAZARD_STATS_EN adds two saturating event counters,
// stall_cycles and flush_events.
//
// MDU FSM states
//   state | meaning
//   IDLE  | no mult/div outstanding; the front end runs unless lu or a branch intervenes
//   BUSY  | mult/div occupying EX; the front end is stalled until cnt_q reaches 0
module hazard_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic [4:0]  EX_rs,
    input  logic [4:0]  EX_rt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_WriteReg,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_WriteReg,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_WriteReg,
    input  logic        ID_mdu_start,
    input  logic        EX_branch_taken,
    output logic [1:0]  forwardA,
    output logic [1:0]  forwardB,
    output logic        PC_write,
    output logic        IFID_write,
    output logic        IFID_flush,
    output logic        IDEX_flush,
    output logic        mdu_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // A single-cycle MDU never needs a stall, so BUSY is only reachable when the latency is above 1.
    localparam bit MDU_MULTI = (MDU_LATENCY > 1);
    // The start cycle is one MDU cycle, so the counter is loaded with MDU_LATENCY-2.
    // This gives MDU_LATENCY-1 cycles in BUSY.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MDU_LATENCY > 1) ? (MDU_LATENCY - 2) : 0);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] fwd_a, fwd_b;
    logic       lu;
    logic       pc_write_c, ifid_write_c, ifid_flush_c, idex_flush_c;

    // Forward selects: a MEM-stage producer beats a WB-stage producer, and $zero is never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        if (MEM_RegWrite && (MEM_WriteReg != 5'd0) && (MEM_WriteReg == EX_rs)) begin
            fwd_a = 2'b10;
        end else if (WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == EX_rs)) begin
            fwd_a = 2'b01;
        end
        fwd_b = 2'b00;
        if (MEM_RegWrite && (MEM_WriteReg != 5'd0) && (MEM_WriteReg == EX_rt)) begin
            fwd_b = 2'b10;
        end else if (WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == EX_rt)) begin
            fwd_b = 2'b01;
        end
    end

    // Load-use detection: a load in EX whose destination is read by the instruction in ID.
    always_comb begin
        lu = EX_MemRead && (EX_WriteReg != 5'd0) &&
             ((EX_WriteReg == ID_rs) || (EX_WriteReg == ID_rt));
    end

    // Front-end control, priority branch > MDU stall > load-use.
    always_comb begin
        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        if (EX_branch_taken) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
        end else if (state_q == ST_BUSY) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            idex_flush_c = 1'b1;
        end else if (lu) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            idex_flush_c = 1'b1;
        end
    end

    // MDU next-state and down-counter. A start is only accepted in IDLE on a cycle where the start instruction really advances.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (ID_mdu_start && !lu && !EX_branch_taken && MDU_MULTI) begin
                state_d = ST_BUSY;
                cnt_d   = CNT_LOAD;
            end
        end else begin
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // MDU state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign forwardA   = fwd_a;
    assign forwardB   = fwd_b;
    assign PC_write   = pc_write_c;
    assign IFID_write = ifid_write_c;
    assign IFID_flush = ifid_flush_c;
    assign IDEX_flush = idex_flush_c;
    assign mdu_busy   = (state_q == ST_BUSY);

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    // Saturating event counters. They count stalled PC cycles and cycles with an IF/ID flush.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (!pc_write_c && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (ifid_flush_c && (flush_events_q != 32'hFFFF_FFFF)) begin
            flush_events_d = flush_events_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with the default MDU_LATENCY of 4.
// It works with or without HAZARD_STATS_EN defined.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ID_rs, ID_rt, EX_rs, EX_rt, EX_WriteReg, MEM_WriteReg, WB_WriteReg;
    logic        EX_MemRead, MEM_RegWrite, WB_RegWrite, ID_mdu_start, EX_branch_taken;
    logic [1:0]  forwardA, forwardB;
    logic        PC_write, IFID_write, IFID_flush, IDEX_flush, mdu_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(6)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ID_rs           (ID_rs),
        .ID_rt           (ID_rt),
        .EX_rs           (EX_rs),
        .EX_rt           (EX_rt),
        .EX_MemRead      (EX_MemRead),
        .EX_WriteReg     (EX_WriteReg),
        .MEM_RegWrite    (MEM_RegWrite),
        .MEM_WriteReg    (MEM_WriteReg),
        .WB_RegWrite     (WB_RegWrite),
        .WB_WriteReg     (WB_WriteReg),
        .ID_mdu_start    (ID_mdu_start),
        .EX_branch_taken (EX_branch_taken),
        .forwardA        (forwardA),
        .forwardB        (forwardB),
        .PC_write        (PC_write),
        .IFID_write      (IFID_write),
        .IFID_flush      (IFID_flush),
        .IDEX_flush      (IDEX_flush),
        .mdu_busy        (mdu_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag any taken branch while the MDU is busy.
    always @(negedge clk) begin
        if (rst_n && mdu_busy && EX_branch_taken) begin
            errors++;
            $display("FAIL branch_in_busy: EX_branch_taken=1 while mdu_busy=1");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        ID_rs = 0; ID_rt = 0; EX_rs = 0; EX_rt = 0;
        EX_MemRead = 0; EX_WriteReg = 0;
        MEM_RegWrite = 0; MEM_WriteReg = 0;
        WB_RegWrite = 0; WB_WriteReg = 0;
        ID_mdu_start = 0; EX_branch_taken = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", mdu_busy); end
        checks++; if (PC_write !== 1'b1) begin errors++; $display("FAIL reset_pc_write: got %b exp 1", PC_write); end
        checks++; if ({IFID_write, IFID_flush, IDEX_flush} !== 3'b100) begin errors++; $display("FAIL reset_ctrl: got %b exp 100", {IFID_write, IFID_flush, IDEX_flush}); end
        checks++; if ({forwardA, forwardB} !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b exp 0000", {forwardA, forwardB}); end
`ifdef HAZARD_STATS_EN
        checks++; if ({stall_cycles, flush_events} !== 64'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d exp 0/0", stall_cycles, flush_events); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_forwarding();
        clear_inputs();
        MEM_RegWrite = 1; MEM_WriteReg = 5; WB_RegWrite = 1; WB_WriteReg = 5; EX_rs = 5;
        #1;
        checks++; if (forwardA !== 2'b10) begin errors++; $display("FAIL fwdA_mem_priority: got %b exp 10", forwardA); end
        MEM_RegWrite = 0;
        #1;
        checks++; if (forwardA !== 2'b01) begin errors++; $display("FAIL fwdA_wb: got %b exp 01", forwardA); end
        clear_inputs();
        MEM_RegWrite = 1; MEM_WriteReg = 0; EX_rs = 0; EX_rt = 0;
        #1;
        checks++; if ({forwardA, forwardB} !== 4'b0000) begin errors++; $display("FAIL fwd_zero_reg: got %b exp 0000", {forwardA, forwardB}); end
        clear_inputs();
        MEM_RegWrite = 1; MEM_WriteReg = 7; WB_RegWrite = 1; WB_WriteReg = 9; EX_rs = 9; EX_rt = 7;
        #1;
        checks++; if ({forwardA, forwardB} !== 4'b0110) begin errors++; $display("FAIL fwd_split: got %b exp 0110", {forwardA, forwardB}); end
        EX_rt = 9; WB_RegWrite = 0;
        #1;
        checks++; if ({forwardA, forwardB} !== 4'b0000) begin errors++; $display("FAIL fwd_wb_disabled: got %b exp 0000", {forwardA, forwardB}); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        next_cycle();
        clear_inputs();
        EX_MemRead = 1; EX_WriteReg = 8; ID_rt = 8;
        #1;
        checks++; if ({PC_write, IFID_write, IDEX_flush, IFID_flush} !== 4'b0010) begin errors++; $display("FAIL lu_rt_stall: got %b exp 0010", {PC_write, IFID_write, IDEX_flush, IFID_flush}); end
        next_cycle();
        clear_inputs();
        #1;
        checks++; if ({PC_write, IFID_write, IDEX_flush, IFID_flush} !== 4'b1100) begin errors++; $display("FAIL lu_release: got %b exp 1100", {PC_write, IFID_write, IDEX_flush, IFID_flush}); end
        EX_MemRead = 1; EX_WriteReg = 12; ID_rs = 12;
        #1;
        checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL lu_rs_stall: got %b exp 0", PC_write); end
        EX_WriteReg = 0; ID_rs = 0; ID_rt = 0;
        #1;
        checks++; if (PC_write !== 1'b1) begin errors++; $display("FAIL lu_zero_dest: got %b exp 1", PC_write); end
        EX_MemRead = 0; EX_WriteReg = 12; ID_rs = 12;
        #1;
        checks++; if (PC_write !== 1'b1) begin errors++; $display("FAIL lu_not_load: got %b exp 1", PC_write); end
        clear_inputs();
    endtask

    task automatic test_mdu();
        next_cycle();
        clear_inputs();
        ID_mdu_start = 1;
        #1;
        checks++; if ({mdu_busy, PC_write} !== 2'b01) begin errors++; $display("FAIL mdu_start_cycle: got %b exp 01", {mdu_busy, PC_write}); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            ID_mdu_start = 0;
            #1;
            checks++; if ({mdu_busy, PC_write, IFID_write, IDEX_flush} !== 4'b1001) begin errors++; $display("FAIL mdu_stall_%0d: got %b exp 1001", i, {mdu_busy, PC_write, IFID_write, IDEX_flush}); end
        end
        next_cycle();
        #1;
        checks++; if ({mdu_busy, PC_write, IFID_write, IDEX_flush} !== 4'b0110) begin errors++; $display("FAIL mdu_done: got %b exp 0110", {mdu_busy, PC_write, IFID_write, IDEX_flush}); end
    endtask

    task automatic test_mdu_held_start();
        next_cycle();
        clear_inputs();
        ID_mdu_start = 1;
        #1;
        checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL held_c0: got %b exp 0", mdu_busy); end
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            #1;
            checks++; if ({mdu_busy, PC_write} !== 2'b10) begin errors++; $display("FAIL held_busy_c%0d: got %b exp 10", i, {mdu_busy, PC_write}); end
        end
        next_cycle();
        #1;
        checks++; if ({mdu_busy, PC_write} !== 2'b01) begin errors++; $display("FAIL held_c4_idle: got %b exp 01", {mdu_busy, PC_write}); end
        next_cycle();
        #1;
        checks++; if (mdu_busy !== 1'b1) begin errors++; $display("FAIL held_c5_restart: got %b exp 1", mdu_busy); end
        ID_mdu_start = 0;
        next_cycle();
        next_cycle();
        #1;
        checks++; if (mdu_busy !== 1'b1) begin errors++; $display("FAIL held_c7_busy: got %b exp 1", mdu_busy); end
        next_cycle();
        #1;
        checks++; if ({mdu_busy, PC_write} !== 2'b01) begin errors++; $display("FAIL held_c8_idle: got %b exp 01", {mdu_busy, PC_write}); end
    endtask

    task automatic test_mdu_with_lu();
        next_cycle();
        clear_inputs();
        ID_mdu_start = 1; EX_MemRead = 1; EX_WriteReg = 3; ID_rs = 3;
        #1;
        checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL mdu_lu_stall: got %b exp 0", PC_write); end
        next_cycle();
        clear_inputs();
        #1;
        checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL mdu_lu_no_start: got %b exp 0", mdu_busy); end
    endtask

    task automatic test_branch();
        next_cycle();
        clear_inputs();
        EX_MemRead = 1; EX_WriteReg = 4; ID_rt = 4; EX_branch_taken = 1; ID_mdu_start = 1;
        #1;
        checks++; if ({PC_write, IFID_write, IFID_flush, IDEX_flush} !== 4'b1111) begin errors++; $display("FAIL branch_ctrl: got %b exp 1111", {PC_write, IFID_write, IFID_flush, IDEX_flush}); end
        next_cycle();
        clear_inputs();
        #1;
        checks++; if ({mdu_busy, IFID_flush} !== 2'b00) begin errors++; $display("FAIL branch_no_mdu: got %b exp 00", {mdu_busy, IFID_flush}); end
    endtask

    task automatic test_reset_mid_busy();
        next_cycle();
        clear_inputs();
        ID_mdu_start = 1;
        next_cycle();
        ID_mdu_start = 0;
        next_cycle();
        #1;
        checks++; if (mdu_busy !== 1'b1) begin errors++; $display("FAIL rst_busy_pre: got %b exp 1", mdu_busy); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({mdu_busy, PC_write, IFID_write, IDEX_flush} !== 4'b0110) begin errors++; $display("FAIL rst_async_abort: got %b exp 0110", {mdu_busy, PC_write, IFID_write, IDEX_flush}); end
`ifdef HAZARD_STATS_EN
        checks++; if ({stall_cycles, flush_events} !== 64'd0) begin errors++; $display("FAIL rst_stats_clear: got %0d/%0d exp 0/0", stall_cycles, flush_events); end
`endif
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        #1;
        checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL rst_stays_idle: got %b exp 0", mdu_busy); end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        clear_inputs();
        next_cycle();
        EX_MemRead = 1; EX_WriteReg = 6; ID_rs = 6;
        next_cycle();
        clear_inputs();
        EX_branch_taken = 1;
        next_cycle();
        clear_inputs();
        #1;
        checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL stats_stall: got %0d exp 1", stall_cycles); end
        checks++; if (flush_events !== 32'd1) begin errors++; $display("FAIL stats_flush: got %0d exp 1", flush_events); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu();
        test_mdu_held_start();
        test_mdu_with_lu();
        test_branch();
        test_reset_mid_busy();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
